mem_block_engine: RTL and testbench

//  Initiator side of the single-port data memory: a block-transfer engine that owns the memory's

---
 rtl/mem_block_engine_pkg.sv | 18 +
 rtl/mem_block_engine_if.sv | 26 ++
 rtl/mem_block_engine.sv | 130 +++++++++++++
 tb/tb_mem_block_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_block_engine_pkg.sv
// rtl/mem_block_engine_pkg.sv - command opcodes and FSM states for the block-transfer engine
package mem_engine_pkg;

  typedef enum logic [1:0] {
    OP_COPY = 2'd0,
    OP_FILL = 2'd1,
    OP_SUM  = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_block_engine_if.sv
// rtl/mem_block_engine_if.sv - single-port data memory pins: engine drives, memory answers
interface mem_block_engine_if #(
  parameter int W = 8,
  parameter int A = 8
);

  logic         MemWriteEn;
  logic [A-1:0] MemAddress;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;

  modport master (
    output MemWriteEn,
    output MemAddress,
    output MemDataIn,
    input  MemDataOut
  );

  modport slave (
    input  MemWriteEn,
    input  MemAddress,
    input  MemDataIn,
    output MemDataOut
  );

endinterface

// File: rtl/mem_block_engine.sv
// rtl/mem_block_engine.sv - COPY/FILL/SUM block engine; passes CPU accesses through when idle
module mem_block_engine
  import mem_engine_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8,
  parameter int S = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [1:0]          Op,
  input  logic [A-1:0]        SrcAddr,
  input  logic [A-1:0]        DstAddr,
  input  logic [A-1:0]        Len,
  input  logic [W-1:0]        FillVal,
  output logic                Busy,
  output logic                Done,
  output logic [S-1:0]        Sum,
  input  logic                CpuWriteEn,
  input  logic [A-1:0]        CpuAddress,
  input  logic [W-1:0]        CpuDataIn,
  mem_block_engine_if.master  mem
);

  state_t       state_q, state_d;
  op_t          op_q, op_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A-1:0] count_q, count_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] fill_q, fill_d;
  logic [S-1:0] sum_q, sum_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    src_d          = src_q;
    dst_d          = dst_q;
    count_d        = count_q;
    data_d         = data_q;
    fill_d         = fill_q;
    sum_d          = sum_q;
    Busy           = 1'b1;
    Done           = 1'b0;
    mem.MemWriteEn = 1'b0;
    mem.MemAddress = '0;
    mem.MemDataIn  = '0;

    case (state_q)
      IDLE: begin
        Busy           = 1'b0;
        mem.MemWriteEn = CpuWriteEn;
        mem.MemAddress = CpuAddress;
        mem.MemDataIn  = CpuDataIn;
        if (Start) begin
          op_d    = op_t'(Op);
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          count_d = Len;
          fill_d  = FillVal;
          sum_d   = '0;
          if (Len == '0 || op_t'(Op) == OP_RSVD) state_d = DONE;
          else if (op_t'(Op) == OP_FILL)         state_d = WRITE;
          else                                   state_d = READ;
        end
      end

      READ: begin
        mem.MemAddress = src_q;
        if (op_q == OP_SUM) begin
          sum_d   = sum_q + S'(mem.MemDataOut);
          src_d   = src_q + A'(1);
          count_d = count_q - A'(1);
          state_d = (count_q == A'(1)) ? DONE : READ;
        end else begin
          data_d  = mem.MemDataOut;
          state_d = WRITE;
        end
      end

      WRITE: begin
        mem.MemAddress = dst_q;
        mem.MemWriteEn = 1'b1;
        mem.MemDataIn  = (op_q == OP_FILL) ? fill_q : data_q;
        dst_d          = dst_q + A'(1);
        if (op_q == OP_COPY) src_d = src_q + A'(1);
        count_d = count_q - A'(1);
        if (count_q == A'(1))      state_d = DONE;
        else if (op_q == OP_COPY)  state_d = READ;
        else                       state_d = WRITE;
      end

      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A reset cycle must never commit a write, whether from the engine or from the core.
    if (Reset) mem.MemWriteEn = 1'b0;
  end

  assign Sum = sum_q;

endmodule

// File: tb/tb_mem_block_engine.sv
// tb/tb_mem_block_engine.sv - scoreboard bench for mem_block_engine with a 256x8 behavioural memory
module tb_mem_block_engine;
  import mem_engine_pkg::*;

  localparam int W = 8;
  localparam int A = 8;
  localparam int S = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    Op;
  logic [A-1:0]  SrcAddr, DstAddr, Len;
  logic [W-1:0]  FillVal;
  logic          Busy, Done;
  logic [S-1:0]  Sum;
  logic          CpuWriteEn;
  logic [A-1:0]  CpuAddress;
  logic [W-1:0]  CpuDataIn;

  mem_block_engine_if #(.W(W), .A(A)) mif ();

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  assign mif.MemDataOut = mem[mif.MemAddress];
  always @(posedge Clk) if (mif.MemWriteEn) mem[mif.MemAddress] <= mif.MemDataIn;

  always #5 Clk = ~Clk;

  mem_block_engine #(.W(W), .A(A), .S(S)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .FillVal    (FillVal),
    .Busy       (Busy),
    .Done       (Done),
    .Sum        (Sum),
    .CpuWriteEn (CpuWriteEn),
    .CpuAddress (CpuAddress),
    .CpuDataIn  (CpuDataIn),
    .mem        (mif)
  );

  typedef struct {
    int          lat;
    int          busy;
    int          nwr;
    logic [15:0] sum;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    CpuWriteEn = 1'b1;
    CpuAddress = a;
    CpuDataIn  = d;
    @(negedge Clk);
    CpuWriteEn = 1'b0;
  endtask

  task automatic mem_all(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                       input logic [7:0] len, input logic [7:0] fill, input bit disturb);
    exp_t       e, g;
    logic [7:0] sa, da;
    logic [7:0] old5;
    bit         valid, got;
    int         busy_n, wr_n, lat;
    valid  = (len != 8'd0) && (op != 2'd3);
    e.sum  = 16'd0;
    e.nwr  = 0;
    sa     = src;
    da     = dst;
    // Reference model: strict forward byte order, so overlapping COPY propagates earlier bytes.
    if (valid) begin
      for (int i = 0; i < int'(len); i++) begin
        case (op)
          2'd0:    exp_mem[da] = exp_mem[sa];
          2'd1:    exp_mem[da] = fill;
          default: e.sum = e.sum + 16'(exp_mem[sa]);
        endcase
        sa++;
        da++;
      end
    end
    if (!valid)         e.lat = 1;
    else if (op == 2'd0) e.lat = 2 * int'(len) + 1;
    else                 e.lat = int'(len) + 1;
    e.busy = e.lat;
    e.nwr  = (valid && op != 2'd2) ? int'(len) : 0;
    sb.push_back(e);

    @(negedge Clk);
    Start   = 1'b1;
    Op      = op;
    SrcAddr = src;
    DstAddr = dst;
    Len     = len;
    FillVal = fill;
    @(posedge Clk);
    #1 Start = 1'b0;

    old5   = exp_mem[5];
    got    = 1'b0;
    busy_n = 0;
    wr_n   = 0;
    lat    = 0;
    for (int idx = 1; idx <= 600 && !got; idx++) begin
      @(negedge Clk);
      if (Busy) busy_n++;
      if (mif.MemWriteEn) wr_n++;
      if (Done) begin
        got = 1'b1;
        lat = idx;
        if (disturb) begin
          check("cpu_blocked", 32'(mem[5]), 32'(old5));
          CpuWriteEn = 1'b0;
        end
      end
      if (disturb && idx == 2) begin
        Start      = 1'b1;
        Op         = 2'd1;
        DstAddr    = 8'h05;
        Len        = 8'd1;
        FillVal    = 8'hEE;
        CpuWriteEn = 1'b1;
        CpuAddress = 8'h05;
        CpuDataIn  = 8'h77;
      end
      if (disturb && idx == 3) Start = 1'b0;
    end

    g = sb.pop_front();
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_latency", 32'(lat), 32'(g.lat));
      check("busy_cycles", 32'(busy_n), 32'(g.busy));
      check("write_count", 32'(wr_n), 32'(g.nwr));
      check("sum_result", 32'(Sum), 32'(g.sum));
    end
  endtask

  initial begin
    int done_n;
    Reset      = 1'b1;
    Start      = 1'b0;
    Op         = 2'd0;
    SrcAddr    = '0;
    DstAddr    = '0;
    Len        = '0;
    FillVal    = '0;
    CpuWriteEn = 1'b1;
    CpuAddress = 8'hF0;
    CpuDataIn  = 8'h99;

    repeat (2) @(negedge Clk);
    check("rst_memwe_forced", 32'(mif.MemWriteEn), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    CpuWriteEn = 1'b0;
    Reset      = 1'b0;

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 37 + 11);
    exp_mem[8'h10] = 8'h11; exp_mem[8'h11] = 8'h22; exp_mem[8'h12] = 8'h33; exp_mem[8'h13] = 8'h44;
    exp_mem[8'h00] = 8'hFF; exp_mem[8'h01] = 8'hFF; exp_mem[8'h02] = 8'hFF; exp_mem[8'h03] = 8'h01;
    for (int i = 0; i < 256; i++) cpu_write(8'(i), exp_mem[i]);
    @(negedge Clk);
    mem_all("preload_passthrough");

    issue(2'd0, 8'h10, 8'h80, 8'd4, 8'h00, 1'b0);
    check("copy_80", 32'(mem[8'h80]), 32'h11);
    check("copy_81", 32'(mem[8'h81]), 32'h22);
    check("copy_82", 32'(mem[8'h82]), 32'h33);
    check("copy_83", 32'(mem[8'h83]), 32'h44);
    mem_all("copy_mem");

    issue(2'd2, 8'h00, 8'h00, 8'd4, 8'h00, 1'b0);
    check("sum_value", 32'(Sum), 32'h02FE);
    repeat (3) @(negedge Clk);
    check("sum_hold", 32'(Sum), 32'h02FE);

    issue(2'd1, 8'h00, 8'hFE, 8'd4, 8'hA5, 1'b0);
    check("fill_fe", 32'(mem[8'hFE]), 32'hA5);
    check("fill_ff", 32'(mem[8'hFF]), 32'hA5);
    check("fill_00", 32'(mem[8'h00]), 32'hA5);
    check("fill_01", 32'(mem[8'h01]), 32'hA5);
    check("fill_02_kept", 32'(mem[8'h02]), 32'hFF);
    check("sum_cleared", 32'(Sum), 32'd0);
    mem_all("fill_mem");

    issue(2'd0, 8'h10, 8'h30, 8'd0, 8'h00, 1'b0);
    issue(2'd3, 8'h10, 8'h30, 8'd5, 8'h5A, 1'b0);
    mem_all("empty_rsvd_mem");

    issue(2'd0, 8'h80, 8'h81, 8'd3, 8'h00, 1'b0);
    check("overlap_83", 32'(mem[8'h83]), 32'h11);
    mem_all("overlap_mem");

    issue(2'd0, 8'h20, 8'h90, 8'd3, 8'h00, 1'b1);
    cpu_write(8'h05, 8'h77);
    exp_mem[5] = 8'h77;
    check("no_ghost_busy", 32'(Busy), 32'd0);
    check("cpu_landed", 32'(mem[5]), 32'h77);
    mem_all("disturb_mem");

    // Abort a FILL during its third write: two entries land, the rest stay untouched.
    @(negedge Clk);
    Start   = 1'b1;
    Op      = 2'd1;
    DstAddr = 8'h40;
    Len     = 8'd8;
    FillVal = 8'h3C;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_we", 32'(mif.MemWriteEn), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_sum", 32'(Sum), 32'd0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    exp_mem[8'h40] = 8'h3C;
    exp_mem[8'h41] = 8'h3C;
    check("abort_40", 32'(mem[8'h40]), 32'h3C);
    check("abort_41", 32'(mem[8'h41]), 32'h3C);
    mem_all("abort_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
